// File: rtl/alarm_ring_controller_if.sv
// Alarm ring controller bus: alarm/button inputs from upstream, buzzer/status outputs to the pins.
// Upstream (time-compare stage, button conditioning) drives through master; the controller uses slave.
interface alarm_ring_controller_if;
  logic       alarm_match;
  logic       armed;
  logic       snooze_btn;
  logic       stop_btn;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [2:0] snooze_count;
  logic       missed;
  logic [1:0] state;

  modport master (
    output alarm_match, armed, snooze_btn, stop_btn,
    input  buzzer, ringing, snoozing, snooze_count, missed, state
  );

  modport slave (
    input  alarm_match, armed, snooze_btn, stop_btn,
    output buzzer, ringing, snoozing, snooze_count, missed, state
  );
endinterface

// File: rtl/alarm_ring_controller.sv
// Turns the one-cycle alarm match pulse into a beeping ring sequence with bounded snooze,
// stop control and a ring timeout that leaves a sticky missed-alarm flag.
module alarm_ring_controller #(
  parameter int BEEP_ON       = 2,
  parameter int BEEP_OFF      = 2,
  parameter int RING_TIMEOUT  = 16,
  parameter int SNOOZE_CYCLES = 8,
  parameter int MAX_SNOOZE    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  alarm_ring_controller_if.slave  bus
);

  localparam int BEEP_PERIOD = BEEP_ON + BEEP_OFF;
  localparam int BEEP_W      = $clog2(BEEP_PERIOD);
  localparam int RING_W      = $clog2(RING_TIMEOUT);
  localparam int SNZ_W       = (SNOOZE_CYCLES > 1) ? $clog2(SNOOZE_CYCLES) : 1;

  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_PERIOD - 1);
  localparam logic [BEEP_W-1:0] BEEP_ON_V = BEEP_W'(BEEP_ON);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_CYCLES - 1);
  localparam logic [2:0]        SNZ_MAX   = 3'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
  logic [RING_W-1:0]   ring_tmr_q, ring_tmr_d;
  logic [SNZ_W-1:0]    snz_tmr_q, snz_tmr_d;
  logic [2:0]          snooze_count_q, snooze_count_d;
  logic                missed_q, missed_d;
  logic                snooze_btn_q, stop_btn_q;
  logic                snooze_press, stop_press;

  assign snooze_press = bus.snooze_btn & ~snooze_btn_q;
  assign stop_press   = bus.stop_btn & ~stop_btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      beep_cnt_q     <= '0;
      ring_tmr_q     <= '0;
      snz_tmr_q      <= '0;
      snooze_count_q <= '0;
      missed_q       <= 1'b0;
      snooze_btn_q   <= 1'b0;
      stop_btn_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      beep_cnt_q     <= beep_cnt_d;
      ring_tmr_q     <= ring_tmr_d;
      snz_tmr_q      <= snz_tmr_d;
      snooze_count_q <= snooze_count_d;
      missed_q       <= missed_d;
      snooze_btn_q   <= bus.snooze_btn;
      stop_btn_q     <= bus.stop_btn;
    end
  end

  // Stop (or disarm) beats snooze, and any accepted press beats the timeout in the same cycle.
  always_comb begin
    state_d        = state_q;
    beep_cnt_d     = beep_cnt_q;
    ring_tmr_d     = ring_tmr_q;
    snz_tmr_d      = snz_tmr_q;
    snooze_count_d = snooze_count_q;
    missed_d       = missed_q;

    case (state_q)
      IDLE: begin
        if (bus.alarm_match && bus.armed) begin
          state_d        = RING;
          beep_cnt_d     = '0;
          ring_tmr_d     = '0;
          snooze_count_d = '0;
          missed_d       = 1'b0;
        end else if (stop_press) begin
          missed_d = 1'b0;
        end
      end

      RING: begin
        if (!bus.armed || stop_press) begin
          state_d        = IDLE;
          snooze_count_d = '0;
        end else if (snooze_press && (snooze_count_q < SNZ_MAX)) begin
          state_d        = SNOOZE;
          snooze_count_d = snooze_count_q + 3'd1;
          snz_tmr_d      = '0;
        end else if (ring_tmr_q == RING_LAST) begin
          state_d        = IDLE;
          missed_d       = 1'b1;
          snooze_count_d = '0;
        end else begin
          ring_tmr_d = ring_tmr_q + RING_W'(1);
          beep_cnt_d = (beep_cnt_q == BEEP_LAST) ? '0 : beep_cnt_q + BEEP_W'(1);
        end
      end

      SNOOZE: begin
        if (!bus.armed || stop_press) begin
          state_d        = IDLE;
          snooze_count_d = '0;
        end else if (snz_tmr_q == SNZ_LAST) begin
          state_d    = RING;
          ring_tmr_d = '0;
          beep_cnt_d = '0;
        end else begin
          snz_tmr_d = snz_tmr_q + SNZ_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ringing      = (state_q == RING);
  assign bus.snoozing     = (state_q == SNOOZE);
  assign bus.buzzer       = (state_q == RING) && (beep_cnt_q < BEEP_ON_V);
  assign bus.snooze_count = snooze_count_q;
  assign bus.missed       = missed_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Self-checking bench: an elapsed-time reference model checked every cycle, plus directed scenarios
// with literal expectations for the ring, snooze, stop, reset and disarm behaviour.
module tb_alarm_ring_controller;
  localparam int BEEP_ON       = 2;
  localparam int BEEP_OFF      = 2;
  localparam int RING_TIMEOUT  = 16;
  localparam int SNOOZE_CYCLES = 8;
  localparam int MAX_SNOOZE    = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  alarm_ring_controller_if bus ();

  alarm_ring_controller #(
    .BEEP_ON      (BEEP_ON),
    .BEEP_OFF     (BEEP_OFF),
    .RING_TIMEOUT (RING_TIMEOUT),
    .SNOOZE_CYCLES(SNOOZE_CYCLES),
    .MAX_SNOOZE   (MAX_SNOOZE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: tracks when the current ring/snooze phase began and derives outputs from elapsed time.
  int  cyc = 0;
  int  mState = 0;
  int  ringStart = 0;
  int  snoozeStart = 0;
  int  mCount = 0;
  int  mMissed = 0;
  int  prevSnz = 0;
  int  prevStop = 0;
  bit  modelValid = 1'b0;

  always @(posedge clk) begin
    int sp, tp;
    sp = (bus.snooze_btn && !prevSnz) ? 1 : 0;
    tp = (bus.stop_btn && !prevStop) ? 1 : 0;
    prevSnz  = bus.snooze_btn ? 1 : 0;
    prevStop = bus.stop_btn ? 1 : 0;
    if (reset) begin
      mState = 0; mCount = 0; mMissed = 0;
      prevSnz = 0; prevStop = 0;
      modelValid = 1'b1;
    end else if (mState == 0) begin
      if (bus.alarm_match && bus.armed) begin
        mState = 1; ringStart = cyc + 1; mCount = 0; mMissed = 0;
      end else if (tp != 0) begin
        mMissed = 0;
      end
    end else if (mState == 1) begin
      if (!bus.armed || tp != 0) begin
        mState = 0; mCount = 0;
      end else if (sp != 0 && mCount < MAX_SNOOZE) begin
        mState = 2; snoozeStart = cyc + 1; mCount++;
      end else if (cyc - ringStart == RING_TIMEOUT - 1) begin
        mState = 0; mMissed = 1; mCount = 0;
      end
    end else begin
      if (!bus.armed || tp != 0) begin
        mState = 0; mCount = 0;
      end else if (cyc - snoozeStart == SNOOZE_CYCLES - 1) begin
        mState = 1; ringStart = cyc + 1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (modelValid) begin
      int expBuzz;
      expBuzz = (mState == 1 && ((cyc - ringStart) % (BEEP_ON + BEEP_OFF)) < BEEP_ON) ? 1 : 0;
      checkOutput("model.state",        int'(bus.state), mState);
      checkOutput("model.ringing",      int'(bus.ringing), (mState == 1) ? 1 : 0);
      checkOutput("model.snoozing",     int'(bus.snoozing), (mState == 2) ? 1 : 0);
      checkOutput("model.buzzer",       int'(bus.buzzer), expBuzz);
      checkOutput("model.snooze_count", int'(bus.snooze_count), mCount);
      checkOutput("model.missed",       int'(bus.missed), mMissed);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit alarm, input bit snz, input bit stop);
    bus.alarm_match = alarm;
    bus.snooze_btn  = snz;
    bus.stop_btn    = stop;
    tick(1);
    bus.alarm_match = 1'b0;
    bus.snooze_btn  = 1'b0;
    bus.stop_btn    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bus.alarm_match = 1'b0;
    bus.armed       = 1'b1;
    bus.snooze_btn  = 1'b0;
    bus.stop_btn    = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    checkOutput("reset.state", int'(bus.state), 0);
    checkOutput("reset.snooze_count", int'(bus.snooze_count), 0);
    checkOutput("reset.missed", int'(bus.missed), 0);
    tick(1);

    // Basic ring: 16 cycles of 1,1,0,0 then timeout with missed set.
    applyStimulus(1, 0, 0);
    for (int i = 0; i < RING_TIMEOUT; i++) begin
      checkOutput("basic.ringing", int'(bus.ringing), 1);
      checkOutput("basic.buzzer", int'(bus.buzzer), ((i % 4) < 2) ? 1 : 0);
      tick(1);
    end
    checkOutput("basic.endRinging", int'(bus.ringing), 0);
    checkOutput("basic.missed", int'(bus.missed), 1);
    checkOutput("basic.state", int'(bus.state), 0);
    applyStimulus(0, 0, 1);
    checkOutput("basic.stopClearsMissed", int'(bus.missed), 0);
    tick(1);

    // Disarmed alarm is ignored.
    bus.armed = 1'b0;
    applyStimulus(1, 0, 0);
    checkOutput("disarmed.ringing", int'(bus.ringing), 0);
    checkOutput("disarmed.state", int'(bus.state), 0);
    tick(2);
    bus.armed = 1'b1;

    // Snooze up to the limit, then a fourth press is ignored and the ring times out.
    applyStimulus(1, 0, 0);
    tick(3);
    for (int s = 1; s <= MAX_SNOOZE; s++) begin
      applyStimulus(0, 1, 0);
      for (int i = 0; i < SNOOZE_CYCLES; i++) begin
        checkOutput("snooze.snoozing", int'(bus.snoozing), 1);
        tick(1);
      end
      checkOutput("snooze.reRing", int'(bus.ringing), 1);
      checkOutput("snooze.beepRestart", int'(bus.buzzer), 1);
      checkOutput("snooze.count", int'(bus.snooze_count), s);
      tick(2);
    end
    applyStimulus(0, 1, 0);
    checkOutput("snooze.fourthIgnored", int'(bus.ringing), 1);
    checkOutput("snooze.countHeld", int'(bus.snooze_count), 3);
    n = 0;
    while (bus.ringing && n < 40) begin
      tick(1);
      n++;
    end
    checkOutput("snooze.timeoutReached", int'(bus.ringing), 0);
    checkOutput("snooze.missed", int'(bus.missed), 1);
    checkOutput("snooze.countCleared", int'(bus.snooze_count), 0);
    tick(1);

    // Stop during snooze.
    applyStimulus(1, 0, 0);
    tick(2);
    applyStimulus(0, 1, 0);
    tick(3);
    applyStimulus(0, 0, 1);
    checkOutput("stopSnooze.state", int'(bus.state), 0);
    checkOutput("stopSnooze.count", int'(bus.snooze_count), 0);
    checkOutput("stopSnooze.missed", int'(bus.missed), 0);
    checkOutput("stopSnooze.buzzer", int'(bus.buzzer), 0);
    tick(1);

    // Snooze held for 20 cycles counts once.
    applyStimulus(1, 0, 0);
    tick(1);
    bus.snooze_btn = 1'b1;
    tick(20);
    bus.snooze_btn = 1'b0;
    checkOutput("held.count", int'(bus.snooze_count), 1);
    checkOutput("held.ringing", int'(bus.ringing), 1);
    applyStimulus(0, 0, 1);
    tick(1);

    // Simultaneous stop and snooze resolve as stop.
    applyStimulus(1, 0, 0);
    tick(2);
    applyStimulus(0, 1, 1);
    checkOutput("simul.state", int'(bus.state), 0);
    checkOutput("simul.count", int'(bus.snooze_count), 0);
    tick(1);

    // Stop in the timeout cycle wins.
    applyStimulus(1, 0, 0);
    tick(RING_TIMEOUT - 1);
    checkOutput("lastCycle.ringing", int'(bus.ringing), 1);
    applyStimulus(0, 0, 1);
    checkOutput("lastCycle.state", int'(bus.state), 0);
    checkOutput("lastCycle.missed", int'(bus.missed), 0);
    tick(1);

    // Reset in ring cycle 5.
    applyStimulus(1, 0, 0);
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("midReset.state", int'(bus.state), 0);
    checkOutput("midReset.buzzer", int'(bus.buzzer), 0);
    checkOutput("midReset.ringing", int'(bus.ringing), 0);
    checkOutput("midReset.missed", int'(bus.missed), 0);
    tick(1);

    // Disarm during snooze.
    applyStimulus(1, 0, 0);
    tick(1);
    applyStimulus(0, 1, 0);
    tick(2);
    bus.armed = 1'b0;
    tick(1);
    checkOutput("disarmSnooze.state", int'(bus.state), 0);
    checkOutput("disarmSnooze.missed", int'(bus.missed), 0);
    bus.armed = 1'b1;
    tick(1);

    // Alarm re-pulse during ring does not restart the timeout.
    applyStimulus(1, 0, 0);
    n = 0;
    while (bus.ringing && n < 40) begin
      if (n == 4) bus.alarm_match = 1'b1;
      tick(1);
      bus.alarm_match = 1'b0;
      n++;
    end
    checkOutput("retrigger.ringCycles", n, RING_TIMEOUT);
    checkOutput("retrigger.missed", int'(bus.missed), 1);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alarm_ring_controller.md
Name: alarm_ring_controller

Overview:
Downstream consumer of the clock/alarm stage's one-cycle `alarm` match pulse. It turns that pulse into a user-facing ring sequence: a gated on/off beep pattern, snooze with a bounded snooze count, a stop control, and a ring timeout with a sticky missed-alarm flag. It sits between the time-compare stage and the buzzer/LED pins.

Parameters:
- BEEP_ON, 2: cycles buzzer is high per beep period (>=1).
- BEEP_OFF, 2: cycles buzzer is low per beep period (>=1).
- RING_TIMEOUT, 16: RING cycles before auto-stop (>=2).
- SNOOZE_CYCLES, 8: cycles spent in SNOOZE before re-ringing (>=1).
- MAX_SNOOZE, 3: maximum snoozes per alarm event (1..7).

Ports:
- clk, input, 1: single system clock.
- reset, input, 1: synchronous, active-high reset.
- alarm_match, input, 1: alarm pulse from the clock/alarm stage.
- armed, input, 1: alarm enable level.
- snooze_btn, input, 1: snooze button level, already synchronous to clk.
- stop_btn, input, 1: stop button level, already synchronous to clk.
- buzzer, output, 1: beep pattern drive.
- ringing, output, 1: high while state is RING.
- snoozing, output, 1: high while state is SNOOZE.
- snooze_count, output, 3: snoozes used in the current alarm event.
- missed, output, 1: sticky flag; the last alarm event timed out.
- state, output, 2: IDLE=0, RING=1, SNOOZE=2. Encoding 3 is unreachable and recovers to IDLE.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high. At reset every register clears:
  - state goes to IDLE.
  - snooze_count=0, missed=0.
  - All internal counters are 0.
  - Button history registers are 0, so a button held through reset produces one press in the first cycle after reset.
  - Reset overrides every other input in the same cycle. It aborts RING or SNOOZE with no missed flag set.
- Button press detection: press = btn & ~btn_q, where btn_q is the input registered one cycle earlier. Holding a button yields exactly one press.
- Output decoding:
  - ringing = (state==RING); snoozing = (state==SNOOZE).
  - buzzer = (state==RING) && (beep_cnt < BEEP_ON).
  - All outputs decode from registers only; there is no combinational path from inputs to outputs.
- IDLE:
  - If alarm_match && armed is sampled at edge k, state=RING after edge k.
  - On entry: beep_cnt=0, ring_tmr=0, snooze_count=0, missed=0. ringing and buzzer are therefore 1 in cycle k+1.
  - A stop press in IDLE clears missed.
  - alarm_match with armed=0 is ignored.
- RING, one cycle, priority highest first:
  1. armed=0 or stop press: go to IDLE, snooze_count=0, missed unchanged.
  2. Snooze press with snooze_count < MAX_SNOOZE: go to SNOOZE, snooze_count += 1, snz_tmr=0.
     - Snooze press with snooze_count == MAX_SNOOZE: ignored; ringing continues.
  3. ring_tmr == RING_TIMEOUT-1: go to IDLE, missed=1, snooze_count=0.
  4. Otherwise: ring_tmr += 1. beep_cnt += 1, wrapping to 0 after BEEP_ON+BEEP_OFF-1.
- SNOOZE, one cycle, priority highest first:
  1. armed=0 or stop press: go to IDLE, snooze_count=0.
  2. snz_tmr == SNOOZE_CYCLES-1: go to RING with ring_tmr=0, beep_cnt=0. snooze_count is kept.
  3. Otherwise: snz_tmr += 1.
- Re-trigger rule: alarm_match is ignored in RING and SNOOZE. A new event can only start from IDLE.
- Simultaneous inputs: a stop and a snooze press in the same cycle resolve as stop. A press in the timeout cycle wins over the timeout.
- Counter widths: each counter is sized to hold its parameter's maximum minus 1. No counter exceeds its terminal value.
- Timing summary: a full unsnoozed ring lasts exactly RING_TIMEOUT cycles of ringing=1. Each snooze lasts exactly SNOOZE_CYCLES cycles of snoozing=1.

Test Plan:
- Reset then basic ring: reset, armed=1, pulse alarm_match 1 cycle.
  - Next cycle: ringing=1, buzzer pattern 1,1,0,0,1,1,... for 16 cycles.
  - Then ringing=0, missed=1, state=0.
  - A stop press afterwards clears missed to 0.
- Disarmed: armed=0, pulse alarm_match → ringing stays 0, state stays 0.
- Snooze limit:
  - While ringing, press snooze → snoozing=1 for exactly 8 cycles, then ringing=1 with beep restarted at 1, snooze_count=1.
  - Repeat until snooze_count=3.
  - A 4th press is ignored (ringing stays 1).
  - Timeout → missed=1, snooze_count=0.
- Stop during SNOOZE: snooze, then press stop mid-snooze → state=0 next cycle, snooze_count=0, missed=0, buzzer=0.
- Held and simultaneous buttons:
  - Hold snooze 20 cycles while ringing → exactly one snooze counted.
  - Stop and snooze rising on the same cycle → IDLE, snooze_count=0.
  - Stop press exactly in cycle ring_tmr=15 → IDLE with missed=0.
- Reset and disarm mid-operation:
  - Assert reset in RING cycle 5 → all outputs 0 next cycle.
  - Drop armed during SNOOZE → IDLE next cycle, missed=0.
  - alarm_match pulsed during RING → ring_tmr not restarted; timeout still occurs at the original 16 cycles.
